// File: rtl/sprite_renderer.sv
// Single monochrome bitmap sprite: fetches one ROM row per scanline during
// horizontal blanking and shifts it out as a 1-bit gfx stream at sprite_x.
module sprite_renderer #(
  parameter int SPRITE_W  = 8,
  parameter int SPRITE_H  = 8,
  parameter int ADDR_W    = 3,
  parameter int LOAD_HPOS = 257
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8:0]          hpos,
  input  logic [8:0]          vpos,
  input  logic                vsync,
  input  logic [8:0]          sprite_x,
  input  logic [8:0]          sprite_y,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SPRITE_W-1:0] rom_bits,
  output logic                gfx,
  output logic                busy
);

  localparam logic [8:0] LOAD_POS = 9'(LOAD_HPOS);
  localparam logic [4:0] X_LAST   = 5'(SPRITE_W - 1);
  localparam logic [4:0] Y_END    = 5'(SPRITE_H);

  typedef enum logic [2:0] {
    WAIT_VSTART,
    LOAD_SETUP,
    LOAD_FETCH,
    WAIT_HSTART,
    DRAW,
    WAIT_LOAD
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [4:0]          xcount;
  logic [4:0]          ycount;
  logic [SPRITE_W-1:0] outbits;
  logic [SPRITE_W-1:0] shifted;
  logic                abort;

  // vsync pulls any sprite in progress back to idle so the next frame starts clean
  assign abort = vsync && (state != WAIT_VSTART);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VSTART: if (vpos == sprite_y && hpos == LOAD_POS) state_nxt = LOAD_SETUP;
      LOAD_SETUP:  state_nxt = LOAD_FETCH;
      LOAD_FETCH:  state_nxt = WAIT_HSTART;
      WAIT_HSTART: if (hpos == sprite_x) state_nxt = DRAW;
      DRAW: begin
        if (xcount == X_LAST) state_nxt = (ycount == Y_END) ? WAIT_VSTART : WAIT_LOAD;
      end
      WAIT_LOAD:   if (hpos == LOAD_POS) state_nxt = LOAD_SETUP;
      default:     state_nxt = WAIT_VSTART;
    endcase
    if (abort) state_nxt = WAIT_VSTART;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_VSTART;
      xcount   <= '0;
      ycount   <= '0;
      outbits  <= '0;
      rom_addr <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        ycount <= '0;
      end else begin
        case (state)
          WAIT_VSTART: begin
            if (state_nxt == LOAD_SETUP) begin
              ycount   <= '0;
              rom_addr <= '0;
            end
          end
          LOAD_FETCH: begin
            outbits <= rom_bits;
            ycount  <= ycount + 5'd1;
          end
          WAIT_HSTART: if (state_nxt == DRAW) xcount <= '0;
          DRAW:        xcount <= xcount + 5'd1;
          WAIT_LOAD:   if (state_nxt == LOAD_SETUP) rom_addr <= ADDR_W'(ycount);
          default:     ;
        endcase
      end
    end
  end

  // Left shift by xcount brings the current column to the MSB, avoiding a wide bit-select index
  assign shifted = outbits << xcount;
  assign gfx     = (state == DRAW) && shifted[SPRITE_W-1];
  assign busy    = (state != WAIT_VSTART);

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed line-by-line bench for sprite_renderer: drives hpos/vpos/vsync one
// scanline at a time and compares gfx, busy and rom_addr against hand-built tables.
module tb_sprite_renderer;

  localparam int H_TOTAL   = 300;
  localparam int LOAD_HPOS = 257;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic       vsync = 1'b0;
  logic [8:0] sprite_x = '0;
  logic [8:0] sprite_y = '0;
  logic [2:0] rom_addr;
  logic [7:0] rom_bits;
  logic [7:0] rom_q = '0;
  logic       gfx;
  logic       busy;
  logic       strict = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom_tbl [8];
  logic [7:0] row_exp [8];

  logic [H_TOTAL-1:0] cap_gfx;
  logic [H_TOTAL-1:0] cap_busy;
  logic [2:0]         cap_addr [H_TOTAL];

  typedef struct {
    int         v;
    logic       vs;
    logic [8:0] sxa;
    logic [8:0] sxb;
    logic [8:0] sy;
    logic       st;
    logic       drawn;
    int         x0;
    logic [7:0] bits;
    logic       fetch;
    logic [2:0] frow;
    logic       busy_end;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sprite_renderer #(
    .SPRITE_W(8),
    .SPRITE_H(8),
    .ADDR_W(3),
    .LOAD_HPOS(LOAD_HPOS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .vsync(vsync),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .rom_addr(rom_addr),
    .rom_bits(rom_bits),
    .gfx(gfx),
    .busy(busy)
  );

  // Synchronous ROM, one clock of latency; in strict mode the data bus carries
  // inverted (wrong) data except in the single cycle the fetch must capture.
  always @(posedge clk) rom_q <= rom_tbl[rom_addr];
  assign rom_bits = (strict && hpos != 9'(LOAD_HPOS + 2)) ? ~rom_q : rom_q;

  function automatic vec_t mk(int v, logic vs, int sxa, int sxb, int sy, logic st,
                              logic drawn, int x0, logic [7:0] bits,
                              logic fetch, int frow, logic busy_end);
    vec_t r;
    r.v = v; r.vs = vs; r.sxa = 9'(sxa); r.sxb = 9'(sxb); r.sy = 9'(sy); r.st = st;
    r.drawn = drawn; r.x0 = x0; r.bits = bits; r.fetch = fetch; r.frow = 3'(frow);
    r.busy_end = busy_end;
    return r;
  endfunction

  // One full sprite frame: idle line, fetch line sy, rows on sy+1..sy+8, idle line.
  // sprite_x switches from sx0 to sx1 at hpos 150 of line sy+k_sw.
  task automatic add_frame(input int sy, input int sx0, input int sx1, input int k_sw, input logic st);
    vecs.push_back(mk(sy - 1, 1'b0, sx0, sx0, sy, st, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
    for (int k = 0; k <= 9; k++) begin
      int sxa;
      int sxb;
      sxa = (k <= k_sw) ? sx0 : sx1;
      sxb = (k < k_sw) ? sx0 : sx1;
      vecs.push_back(mk(sy + k, 1'b0, sxa, sxb, sy, st,
                        (k >= 1 && k <= 8), sxa + 1, (k >= 1 && k <= 8) ? row_exp[k - 1] : 8'h00,
                        (k <= 7), (k <= 7) ? k : 0, (k <= 7)));
    end
  endtask

  task automatic drive_cycle(input int h, input int v, input logic vs, input logic [8:0] sx,
                             input logic [8:0] sy, input logic st);
    @(posedge clk);
    #1;
    hpos = 9'(h); vpos = 9'(v); vsync = vs; sprite_x = sx; sprite_y = sy; strict = st;
  endtask

  task automatic drive_line(input vec_t t);
    for (int h = 0; h < H_TOTAL; h++) begin
      drive_cycle(h, t.v, t.vs, (h < 150) ? t.sxa : t.sxb, t.sy, t.st);
      @(negedge clk);
      cap_gfx[h]  = gfx;
      cap_busy[h] = busy;
      cap_addr[h] = rom_addr;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_vec(input vec_t t);
    logic [H_TOTAL-1:0] exp;
    int fd;
    exp = '0;
    fd  = -1;
    if (t.drawn) for (int c = 0; c < 8; c++) exp[t.x0 + c] = t.bits[7 - c];
    n_tests++;
    if (cap_gfx !== exp) begin
      n_fail++;
      for (int h = 0; h < H_TOTAL; h++) if (fd < 0 && cap_gfx[h] !== exp[h]) fd = h;
      $display("FAIL gfx line %0d: first diff at hpos %0d got %b want %b", t.v, fd, cap_gfx[fd], exp[fd]);
    end
    n_tests++;
    if (cap_busy[H_TOTAL-1] !== t.busy_end) begin
      n_fail++;
      $display("FAIL busy_end line %0d: got %b want %b", t.v, cap_busy[H_TOTAL-1], t.busy_end);
    end
    if (t.fetch) begin
      n_tests++;
      if (cap_addr[LOAD_HPOS+1] !== t.frow || cap_addr[LOAD_HPOS+2] !== t.frow) begin
        n_fail++;
        $display("FAIL rom_addr line %0d: got %0d/%0d want %0d", t.v,
                 cap_addr[LOAD_HPOS+1], cap_addr[LOAD_HPOS+2], t.frow);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom_tbl[i] = 8'hA5 ^ 8'(i);
    row_exp[0] = 8'hA5; row_exp[1] = 8'hA4; row_exp[2] = 8'hA7; row_exp[3] = 8'hA6;
    row_exp[4] = 8'hA1; row_exp[5] = 8'hA0; row_exp[6] = 8'hA3; row_exp[7] = 8'hA2;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gfx", 32'(gfx), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b1;

    // Basic frame, x/y = 40/20
    add_frame(20, 40, 40, 99, 1'b0);
    // sprite_x moves 40 -> 100 mid-line on vpos 23
    add_frame(20, 40, 100, 3, 1'b0);
    // Sprite near frame bottom completes before vsync at 270
    add_frame(250, 40, 40, 99, 1'b0);
    vecs.push_back(mk(270, 1'b1, 40, 40, 250, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
    // Sprite starting inside vsync is aborted right after the fetch begins, twice
    for (int rep = 0; rep < 2; rep++) begin
      vecs.push_back(mk(264, 1'b0, 40, 40, 265, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
      vecs.push_back(mk(265, 1'b1, 40, 40, 265, 1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b0));
      vecs.push_back(mk(266, 1'b1, 40, 40, 265, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
      vecs.push_back(mk(267, 1'b0, 40, 40, 265, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
    end
    // sprite_x never reached: stuck in WAIT_HSTART until vsync
    vecs.push_back(mk(19, 1'b0, 300, 300, 20, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
    vecs.push_back(mk(20, 1'b0, 300, 300, 20, 1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b1));
    for (int v = 21; v <= 24; v++)
      vecs.push_back(mk(v, 1'b0, 300, 300, 20, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1));
    vecs.push_back(mk(270, 1'b1, 300, 300, 20, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0));
    // Strict 1-clk ROM latency; also shows a clean restart after the abort
    add_frame(20, 40, 40, 99, 1'b1);

    foreach (vecs[i]) begin
      drive_line(vecs[i]);
      check_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of row 2 on vpos 23
    vecs.delete();
    add_frame(20, 40, 40, 99, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_line(vecs[i]);
      check_vec(vecs[i]);
    end
    for (int h = 0; h <= 43; h++) drive_cycle(h, 23, 1'b0, 9'd40, 9'd20, 1'b0);
    #1;
    chk("pre-reset gfx", 32'(gfx), 32'd1);
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset rom_addr", 32'(rom_addr), 32'd2);
    reset = 1'b0;
    #1;
    chk("async reset gfx", 32'(gfx), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset rom_addr", 32'(rom_addr), 32'd0);
    for (int h = 44; h < H_TOTAL; h++) drive_cycle(h, 23, 1'b0, 9'd40, 9'd20, 1'b0);
    reset = 1'b1;

    vecs.delete();
    add_frame(20, 40, 40, 99, 1'b0);
    foreach (vecs[i]) begin
      drive_line(vecs[i]);
      check_vec(vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
